// File: rtl/split_tracked.sv
// One-master to N-slave bus splitter with a latched per-transaction select.
// Optional hung-slave timeout is enabled by defining SPLIT_TIMEOUT_EN.
`ifndef ADDR_W
`define ADDR_W 32
`endif
`ifndef DATA_W
`define DATA_W 32
`endif
`ifndef STRB_W
`define STRB_W (`DATA_W/8)
`endif
`ifndef REQ_W
`define REQ_W (1+`ADDR_W+`DATA_W+`STRB_W)
`endif
`ifndef RESP_W
`define RESP_W (`DATA_W+1)
`endif
`ifndef ADDR_LSB
`define ADDR_LSB (`DATA_W+`STRB_W)
`endif

module split_tracked #(
  parameter int N_SLAVES   = 2,
  parameter int P_SLAVES   = `ADDR_W-1,
  parameter int N_SLAVES_W = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1,
  parameter int TIMEOUT    = 1024
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [`REQ_W-1:0]            m_req,
  output logic [`RESP_W-1:0]           m_resp,
  output logic [N_SLAVES*`REQ_W-1:0]   s_req,
  input  logic [N_SLAVES*`RESP_W-1:0]  s_resp,
  output logic                         err
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    ERR
  } state_t;

  state_t                  state, state_d;
  logic [N_SLAVES_W-1:0]   sel_q, sel_d;
  logic                    m_valid;
  logic                    sel_ok;
  logic                    s_ready;
  logic                    to_hit;
  logic                    fwd;
  logic [`RESP_W-1:0]      resp_sel;

  assign m_valid = m_req[`REQ_W-1];
  assign sel_d   = (state == IDLE)
                 ? m_req[`ADDR_LSB+P_SLAVES -: N_SLAVES_W]
                 : sel_q;
  assign sel_ok  = int'(sel_d) < N_SLAVES;

  always_comb begin
    resp_sel = '0;
    for (int i = 0; i < N_SLAVES; i++)
      if (sel_d == N_SLAVES_W'(i))
        resp_sel = s_resp[i*`RESP_W +: `RESP_W];
  end

  assign s_ready = resp_sel[0];

`ifdef SPLIT_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT+1);
  logic [CNT_W-1:0] cnt;

  assign to_hit = (cnt == CNT_W'(TIMEOUT-1));

  // Counter only runs while waiting on a selected slave
  always_ff @(posedge clk) begin
    if (rst)
      cnt <= '0;
    else if (state != BUSY)
      cnt <= '0;
    else if (!s_ready)
      cnt <= cnt + 1'b1;
  end
`else
  assign to_hit = 1'b0;
`endif

  always_comb begin
    state_d = state;
    fwd     = 1'b0;
    s_req   = '0;
    m_resp  = '0;
    unique case (state)
      IDLE: begin
        if (m_valid) begin
          if (sel_ok) begin
            fwd     = 1'b1;
            state_d = s_ready ? IDLE : BUSY;
          end else begin
            state_d = ERR;
          end
        end
      end
      BUSY: begin
        if (!m_valid) begin
          state_d = IDLE;
        end else begin
          fwd = 1'b1;
          if (s_ready)
            state_d = IDLE;
          else if (to_hit)
            state_d = ERR;
        end
      end
      ERR: begin
        m_resp  = {{`DATA_W{1'b0}}, 1'b1};
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (fwd) begin
      m_resp = resp_sel;
      for (int i = 0; i < N_SLAVES; i++)
        if (sel_d == N_SLAVES_W'(i))
          s_req[i*`REQ_W +: `REQ_W] = m_req;
    end
    // Outputs are held quiet for the whole reset cycle
    if (rst) begin
      s_req  = '0;
      m_resp = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      sel_q <= '0;
      err   <= 1'b0;
    end else begin
      state <= state_d;
      err   <= (state_d == ERR);
      if (state == IDLE && m_valid)
        sel_q <= sel_d;
    end
  end

endmodule

// File: tb/tb_split_tracked.sv
// Randomized scoreboard bench for split_tracked (3 slaves, 2-bit select).
// Expected responses are queued by the driver and popped by a monitor.
`ifndef ADDR_W
`define ADDR_W 32
`endif
`ifndef DATA_W
`define DATA_W 32
`endif
`ifndef STRB_W
`define STRB_W (`DATA_W/8)
`endif
`ifndef REQ_W
`define REQ_W (1+`ADDR_W+`DATA_W+`STRB_W)
`endif
`ifndef RESP_W
`define RESP_W (`DATA_W+1)
`endif
`ifndef ADDR_LSB
`define ADDR_LSB (`DATA_W+`STRB_W)
`endif

module tb_split_tracked;

  localparam int NS  = 3;
  localparam int TO  = 8;
  localparam int RQW = `REQ_W;
  localparam int RSW = `RESP_W;

  typedef struct {
    int          cyc;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic                clk;
  logic                rst;
  logic [RQW-1:0]      m_req;
  logic [RSW-1:0]      m_resp;
  logic [NS*RQW-1:0]   s_req;
  logic [NS*RSW-1:0]   s_resp;
  logic                err;

  int   cyc;
  int   n_chk;
  int   n_fail;
  int   exp_sel;
  exp_t sbq[$];

  split_tracked #(
    .N_SLAVES (NS),
    .P_SLAVES (`ADDR_W-1),
    .TIMEOUT  (TO)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .m_req  (m_req),
    .m_resp (m_resp),
    .s_req  (s_req),
    .s_resp (s_resp),
    .err    (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act,
                     input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h",
               name, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [NS-1:0] act_v;
    logic [NS-1:0] exp_v;
    exp_t          e;
    if (cyc >= 1) begin
      if (rst) begin
        chk("reset_quiet", {err, m_resp, s_req}, '0);
      end else begin
        exp_v = '0;
        if (exp_sel >= 0 && m_req[RQW-1])
          exp_v[exp_sel] = 1'b1;
        for (int i = 0; i < NS; i++)
          act_v[i] = s_req[i*RQW + RQW-1];
        chk("slave_valid", act_v, exp_v);
        if (exp_sel >= 0)
          chk("req_fwd", s_req[exp_sel*RQW +: RQW], m_req);
        if (m_resp[0]) begin
          if (sbq.size() == 0) begin
            chk("unexpected_ready", 1'b1, 1'b0);
          end else begin
            e = sbq.pop_front();
            chk("ready_cycle", cyc, e.cyc);
            chk("rdata", m_resp[RSW-1:1], e.rdata);
            chk("err_flag", err, e.err);
          end
        end else if (err) begin
          chk("err_without_ready", err, 1'b0);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_resp();
    for (int i = 0; i < NS; i++)
      s_resp[i*RSW +: RSW] = {32'($urandom), 1'($urandom)};
  endtask

  task automatic idle_cycle();
    m_req = {1'b0, 68'({$urandom, $urandom, $urandom})};
    rand_resp();
    exp_sel = -1;
    step();
  endtask

  // One complete master transaction; dly is the slave response delay
  task automatic txn(input int sel, input int dly, input logic [31:0] rd,
                     input bit garb);
    logic [31:0] a;
    int          lat;
    exp_t        e;
    a        = $urandom;
    a[31:30] = 2'(sel);
    lat      = (sel < NS) ? dly : 1;
    e.cyc    = cyc + lat;
    e.rdata  = (sel < NS) ? rd : 32'h0;
    e.err    = (sel >= NS);
    sbq.push_back(e);
    m_req = {1'b1, a, 32'($urandom), 4'($urandom)};
    exp_sel = (sel < NS) ? sel : -1;
    for (int k = 0; k <= lat; k++) begin
      rand_resp();
      if (exp_sel >= 0) begin
        if (k == dly)
          s_resp[exp_sel*RSW +: RSW] = {rd, 1'b1};
        else
          s_resp[exp_sel*RSW] = 1'b0;
      end
      if (k == lat && sel >= NS)
        exp_sel = -1;
      step();
      if (garb && k < lat)
        m_req[`ADDR_LSB +: `ADDR_W] = $urandom;
    end
    m_req   = '0;
    s_resp  = '0;
    exp_sel = -1;
  endtask

  initial begin
    n_chk   = 0;
    n_fail  = 0;
    exp_sel = -1;
    rst     = 1'b1;
    m_req   = {1'b1, 68'({$urandom, $urandom, $urandom})};
    rand_resp();
    repeat (3) @(posedge clk);
    #1;
    rst    = 1'b0;
    m_req  = '0;
    s_resp = '0;
    step();

    txn(1, 0, 32'hCAFE0001, 1'b0);
    txn(0, 5, 32'h1234_5678, 1'b1);
    txn(3, 0, 32'hDEAD_BEEF, 1'b0);
    txn(0, 2, 32'hA5A5_0000, 1'b0);
    txn(1, 1, 32'h5A5A_1111, 1'b0);
    txn(2, 0, 32'h0000_0002, 1'b0);
    txn(3, 0, 32'h0, 1'b1);
    txn(2, 3, 32'hFFFF_FFFF, 1'b1);

    // Abandon a slave-0 transaction with reset in its second BUSY cycle
    m_req = {1'b1, 2'd0, 30'($urandom), 32'($urandom), 4'hF};
    exp_sel = 0;
    for (int k = 0; k < 2; k++) begin
      rand_resp();
      s_resp[0] = 1'b0;
      step();
    end
    rand_resp();
    s_resp[0] = 1'b0;
    rst = 1'b1;
    step();
    rst     = 1'b0;
    m_req   = '0;
    s_resp  = '0;
    exp_sel = -1;
    step();
    txn(1, 2, 32'hB0B0_0001, 1'b0);

    // Slave 0 never answers
    m_req   = {1'b1, 2'd0, 30'($urandom), 32'($urandom), 4'h3};
    exp_sel = 0;
    s_resp  = '0;
`ifdef SPLIT_TIMEOUT_EN
    begin
      exp_t e;
      e.cyc   = cyc + TO + 1;
      e.rdata = 32'h0;
      e.err   = 1'b1;
      sbq.push_back(e);
    end
    repeat (TO + 1) step();
    exp_sel = -1;
    step();
    m_req = '0;
`else
    repeat (100) step();
    chk("still_busy", s_req[RQW-1], 1'b1);
    m_req   = '0;
    exp_sel = -1;
    step();
`endif
    txn(0, 0, 32'h7777_0000, 1'b0);

    for (int t = 0; t < 200; t++) begin
      txn($urandom_range(0, 3), $urandom_range(0, 6), $urandom,
          1'($urandom_range(0, 1)));
      if ($urandom_range(0, 2) == 0)
        repeat ($urandom_range(1, 3)) idle_cycle();
    end
    m_req  = '0;
    s_resp = '0;
    repeat (2) step();

    chk("queue_drain", sbq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
